// File: rtl/pcf8591_seq_pkg.sv
// ============================================================================
// Package : pcf8591_seq_pkg
// Brief   : Shared encodings for the PCF8591 scan sequencer and its helpers.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package pcf8591_seq_pkg;

  typedef logic [1:0] cmd_op_t;

  localparam cmd_op_t c_OP_WRITE     = 2'd0;
  localparam cmd_op_t c_OP_READ_ACK  = 2'd1;
  localparam cmd_op_t c_OP_READ_NACK = 2'd2;
  localparam cmd_op_t c_OP_STOP_ONLY = 2'd3;

  typedef logic [3:0] seq_state_t;

  localparam seq_state_t c_ST_IDLE    = 4'd0;
  localparam seq_state_t c_ST_W_ADDR  = 4'd1;
  localparam seq_state_t c_ST_W_CTRL  = 4'd2;
  localparam seq_state_t c_ST_W_DAC   = 4'd3;
  localparam seq_state_t c_ST_R_ADDR  = 4'd4;
  localparam seq_state_t c_ST_R_DUMMY = 4'd5;
  localparam seq_state_t c_ST_R_DATA  = 4'd6;
  localparam seq_state_t c_ST_EMIT    = 4'd7;
  localparam seq_state_t c_ST_RECOVER = 4'd8;

  // PCF8591 control byte layout: bit6 analog-output enable, low bits channel.
  localparam int c_CTRL_AOUT_BIT = 6;
  localparam int c_CTRL_CH_LSB   = 0;

  function automatic logic is_write_state(input seq_state_t s);
    return (s == c_ST_W_ADDR) || (s == c_ST_W_CTRL) ||
           (s == c_ST_W_DAC)  || (s == c_ST_R_ADDR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_chan_picker.sv
// ============================================================================
// Module : rr_chan_picker
// Brief  : Picks the first enabled channel strictly after the last one, wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_chan_picker #(
  parameter int CHAN_W = 2
) (
  input  logic [(1<<CHAN_W)-1:0] mask,
  input  logic [CHAN_W-1:0]      last,
  output logic [CHAN_W-1:0]      next
);

  localparam int c_NCH = 1 << CHAN_W;

  logic [CHAN_W-1:0] w_idx;

  // Walk from farthest to nearest so the nearest enabled channel wins;
  // k == c_NCH wraps back onto last itself when it is the only one enabled.
  always_comb begin
    next  = last;
    w_idx = last;
    for (int k = c_NCH; k >= 1; k--) begin
      w_idx = last + CHAN_W'(k);
      if (mask[w_idx]) next = w_idx;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pcf8591_scan_sequencer.sv
// ============================================================================
// Module : pcf8591_scan_sequencer
// Brief  : Round-robin PCF8591 ADC scanner issuing byte commands to an I2C master.
//          Define PCF8591_DAC_EN to add the dac_value write phase.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pcf8591_scan_sequencer
  import pcf8591_seq_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR = 7'h48,
  parameter int         CHAN_W   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   sample_tick,
  input  logic [(1<<CHAN_W)-1:0] chan_mask,
`ifdef PCF8591_DAC_EN
  input  logic [7:0]             dac_value,
`endif
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [1:0]             cmd_op,
  output logic                   cmd_start,
  output logic                   cmd_stop,
  output logic [7:0]             cmd_data,
  input  logic                   rsp_valid,
  input  logic [7:0]             rsp_data,
  input  logic                   rsp_nack,
  output logic                   sample_valid,
  output logic [7:0]             sample_data,
  output logic [CHAN_W-1:0]      sample_chan,
  output logic                   busy,
  output logic                   nack_err,
  output logic                   overrun
);

`ifdef PCF8591_DAC_EN
  localparam logic       c_AOUT_EN    = 1'b1;
  localparam logic       c_CTRL_STOP  = 1'b0;
  localparam seq_state_t c_AFTER_CTRL = c_ST_W_DAC;
`else
  localparam logic       c_AOUT_EN    = 1'b0;
  localparam logic       c_CTRL_STOP  = 1'b1;
  localparam seq_state_t c_AFTER_CTRL = c_ST_R_ADDR;
`endif

  seq_state_t        r_state;
  logic              r_issued;
  logic [CHAN_W-1:0] r_ch;
  logic [7:0]        r_sample_data;
  logic [CHAN_W-1:0] r_sample_chan;
  logic              r_nack_err;
  logic              r_overrun;

  logic [CHAN_W-1:0] w_next_ch;
  logic [7:0]        w_ctrl_byte;
  logic [7:0]        w_dac_byte;
  logic              w_cmd_active;
  seq_state_t        w_succ;

  rr_chan_picker #(.CHAN_W(CHAN_W)) u_picker (
    .mask (chan_mask),
    .last (r_ch),
    .next (w_next_ch)
  );

`ifdef PCF8591_DAC_EN
  assign w_dac_byte = dac_value;
`else
  assign w_dac_byte = 8'h00;
`endif

  always_comb begin
    w_ctrl_byte = 8'h00;
    w_ctrl_byte[c_CTRL_AOUT_BIT] = c_AOUT_EN;
    w_ctrl_byte[c_CTRL_CH_LSB +: CHAN_W] = r_ch;
  end

  // Command fields are a pure function of state, so they stay stable while stalled.
  always_comb begin
    w_cmd_active = 1'b1;
    cmd_op       = c_OP_WRITE;
    cmd_start    = 1'b0;
    cmd_stop     = 1'b0;
    cmd_data     = 8'h00;
    case (r_state)
      c_ST_W_ADDR:  begin cmd_start = 1'b1; cmd_data = {I2C_ADDR, 1'b0}; end
      c_ST_W_CTRL:  begin cmd_data = w_ctrl_byte; cmd_stop = c_CTRL_STOP; end
      c_ST_W_DAC:   begin cmd_data = w_dac_byte; cmd_stop = 1'b1; end
      c_ST_R_ADDR:  begin cmd_start = 1'b1; cmd_data = {I2C_ADDR, 1'b1}; end
      c_ST_R_DUMMY: cmd_op = c_OP_READ_ACK;
      c_ST_R_DATA:  begin cmd_op = c_OP_READ_NACK; cmd_stop = 1'b1; end
      c_ST_RECOVER: begin cmd_op = c_OP_STOP_ONLY; cmd_stop = 1'b1; end
      default:      w_cmd_active = 1'b0;
    endcase
  end

  always_comb begin
    case (r_state)
      c_ST_W_ADDR:  w_succ = c_ST_W_CTRL;
      c_ST_W_CTRL:  w_succ = c_AFTER_CTRL;
      c_ST_W_DAC:   w_succ = c_ST_R_ADDR;
      c_ST_R_ADDR:  w_succ = c_ST_R_DUMMY;
      c_ST_R_DUMMY: w_succ = c_ST_R_DATA;
      c_ST_R_DATA:  w_succ = c_ST_EMIT;
      default:      w_succ = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= c_ST_IDLE;
      r_issued      <= 1'b0;
      r_ch          <= '1;
      r_sample_data <= 8'h00;
      r_sample_chan <= '0;
      r_nack_err    <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_nack_err <= 1'b0;
      r_overrun  <= sample_tick && (r_state != c_ST_IDLE);
      if (r_state == c_ST_IDLE) begin
        if (sample_tick && enable && (|chan_mask)) begin
          r_ch    <= w_next_ch;
          r_state <= c_ST_W_ADDR;
        end
      end else if (r_state == c_ST_EMIT) begin
        r_state <= c_ST_IDLE;
      end else if (!w_cmd_active) begin
        r_state  <= c_ST_IDLE;
        r_issued <= 1'b0;
      end else if (!r_issued) begin
        if (cmd_ready) r_issued <= 1'b1;
      end else if (rsp_valid) begin
        r_issued <= 1'b0;
        if (is_write_state(r_state) && rsp_nack) begin
          r_nack_err <= 1'b1;
          r_state    <= c_ST_RECOVER;
        end else begin
          // The R_DUMMY byte is the previous conversion and is dropped.
          if (r_state == c_ST_R_DATA) begin
            r_sample_data <= rsp_data;
            r_sample_chan <= r_ch;
          end
          r_state <= w_succ;
        end
      end
    end
  end

  assign cmd_valid    = w_cmd_active && !r_issued;
  assign sample_valid = (r_state == c_ST_EMIT);
  assign sample_data  = r_sample_data;
  assign sample_chan  = r_sample_chan;
  assign busy         = (r_state != c_ST_IDLE);
  assign nack_err     = r_nack_err;
  assign overrun      = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_pcf8591_scan_sequencer.sv
// ============================================================================
// Module : tb_pcf8591_scan_sequencer
// Brief  : Directed bench for pcf8591_scan_sequencer with an ideal I2C master model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pcf8591_scan_sequencer;

`ifdef PCF8591_DAC_EN
  localparam int         c_NCMD = 6;
  localparam logic [7:0] c_AOUT = 8'h40;
`else
  localparam int         c_NCMD = 5;
  localparam logic [7:0] c_AOUT = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset, enable, sample_tick;
  logic [3:0] chan_mask;
`ifdef PCF8591_DAC_EN
  logic [7:0] dac_value;
`endif
  logic       cmd_valid, cmd_ready, cmd_start, cmd_stop;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid, rsp_nack;
  logic [7:0] rsp_data;
  logic       sample_valid, busy, nack_err, overrun;
  logic [7:0] sample_data;
  logic [1:0] sample_chan;

  pcf8591_scan_sequencer #(.I2C_ADDR(7'h48), .CHAN_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .sample_tick  (sample_tick),
    .chan_mask    (chan_mask),
`ifdef PCF8591_DAC_EN
    .dac_value    (dac_value),
`endif
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_start    (cmd_start),
    .cmd_stop     (cmd_stop),
    .cmd_data     (cmd_data),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_nack     (rsp_nack),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_chan  (sample_chan),
    .busy         (busy),
    .nack_err     (nack_err),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Ideal master: accepts when ready, answers on the following cycle.
  logic [1:0] log_op    [64];
  logic       log_start [64];
  logic       log_stop  [64];
  logic [7:0] log_data  [64];
  int         n_log = 0;
  logic [7:0] dummy_val = 8'h11;
  logic [7:0] data_val  = 8'h00;
  bit         nack_waddr = 0;
  bit         pending = 0;
  bit         pend_nack = 0;
  logic [7:0] pend_data = 8'h00;

  initial begin
    rsp_valid = 1'b0;
    rsp_nack  = 1'b0;
    rsp_data  = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      rsp_valid = 1'b0;
      rsp_nack  = 1'b0;
      if (reset) begin
        pending = 0;
      end else if (pending) begin
        rsp_valid = 1'b1;
        rsp_nack  = pend_nack;
        rsp_data  = pend_data;
        pending   = 0;
      end else if (cmd_valid && cmd_ready) begin
        if (n_log < 64) begin
          log_op[n_log]    = cmd_op;
          log_start[n_log] = cmd_start;
          log_stop[n_log]  = cmd_stop;
          log_data[n_log]  = cmd_data;
          n_log++;
        end
        pend_nack = nack_waddr && (cmd_op == 2'd0) && cmd_start && (cmd_data == 8'h90);
        if (pend_nack) nack_waddr = 0;
        pend_data = (cmd_op == 2'd1) ? dummy_val : (cmd_op == 2'd2) ? data_val : 8'h00;
        pending = 1;
      end
    end
  end

  int         n_samp = 0;
  int         n_nack_cyc = 0;
  int         n_ovr_cyc = 0;
  logic [1:0] last_chan = 2'd0;
  logic [7:0] last_data = 8'h00;
  bit         saw_dummy = 0;

  always @(negedge clk) begin
    if (sample_valid) begin
      n_samp++;
      last_chan = sample_chan;
      last_data = sample_data;
      if (sample_data == 8'h11) saw_dummy = 1;
    end
    if (nack_err) n_nack_cyc++;
    if (overrun)  n_ovr_cyc++;
  end

  int lat;

  // One tick; optional second tick at cycle tick2_k and enable drop at drop_en_k.
  task automatic run_tick(input int tick2_k, input int drop_en_k);
    bit done;
    done  = 0;
    n_log = 0;
    lat   = 0;
    @(negedge clk);
    sample_tick = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 1 || k == tick2_k + 1) sample_tick = 1'b0;
      if (k == tick2_k) sample_tick = 1'b1;
      if (k == drop_en_k) enable = 1'b0;
      if (sample_valid && lat == 0) lat = k;
      if (k > 1 && !busy && !sample_tick) begin
        done = 1;
        break;
      end
    end
    if (!done) check_val("scan_timeout", 32'(busy), 32'd0);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (!busy) begin
        done = 1;
        break;
      end
    end
    if (!done) check_val(tag, 32'(busy), 32'd0);
    #2;
  endtask

  logic [11:0] exp_seq [0:5];
  logic [11:0] act_seq;
  int          bad;
  bit          found;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {op, start, stop, data}; read data bytes are not compared.
    exp_seq[0] = 12'h290;
`ifdef PCF8591_DAC_EN
    exp_seq[1] = 12'h040;
    exp_seq[2] = 12'h180;
    exp_seq[3] = 12'h291;
    exp_seq[4] = 12'h400;
    exp_seq[5] = 12'h900;
    dac_value  = 8'h80;
`else
    exp_seq[1] = 12'h100;
    exp_seq[2] = 12'h291;
    exp_seq[3] = 12'h400;
    exp_seq[4] = 12'h900;
    exp_seq[5] = 12'h000;
`endif
    reset       = 1'b1;
    enable      = 1'b0;
    sample_tick = 1'b0;
    chan_mask   = 4'b0000;
    cmd_ready   = 1'b1;
    repeat (3) @(negedge clk);

    check_val("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_sample_valid", 32'(sample_valid), 32'd0);
    check_val("rst_sample_data", 32'(sample_data), 32'd0);
    check_val("rst_sample_chan", 32'(sample_chan), 32'd0);
    check_val("rst_nack_err", 32'(nack_err), 32'd0);
    check_val("rst_overrun", 32'(overrun), 32'd0);
    check_val("rst_cmd_fields", 32'({cmd_op, cmd_start, cmd_stop, cmd_data}), 32'd0);

    reset     = 1'b0;
    enable    = 1'b1;
    chan_mask = 4'b0101;

    // Scan 1: ch0, full command sequence and latency.
    data_val = 8'hA5;
    run_tick(0, 0);
    check_val("s1_ncmd", 32'(n_log), 32'(c_NCMD));
    for (int i = 0; i < c_NCMD; i++) begin
      act_seq = {log_op[i], log_start[i], log_stop[i],
                 (log_op[i] == 2'd0) ? log_data[i] : 8'h00};
      check_val($sformatf("s1_cmd%0d", i), 32'(act_seq), 32'(exp_seq[i]));
    end
    check_val("s1_latency", 32'(lat), 32'(2 * c_NCMD + 1));
    check_val("s1_nsamp", 32'(n_samp), 32'd1);
    check_val("s1_chan", 32'(last_chan), 32'd0);
    check_val("s1_data", 32'(last_data), 32'hA5);

    data_val = 8'h3C;
    run_tick(0, 0);
    check_val("s2_ctrl", 32'(log_data[1]), 32'(c_AOUT | 8'h02));
    check_val("s2_chan", 32'(last_chan), 32'd2);
    check_val("s2_data", 32'(last_data), 32'h3C);

    data_val = 8'h5A;
    run_tick(0, 0);
    check_val("s3_ctrl", 32'(log_data[1]), 32'(c_AOUT | 8'h00));
    check_val("s3_chan", 32'(last_chan), 32'd0);
    check_val("s3_nsamp", 32'(n_samp), 32'd3);
    check_val("dummy_never_output", 32'(saw_dummy), 32'd0);

    // NACK on the address write of the ch2 scan.
    nack_waddr = 1;
    run_tick(0, 0);
    check_val("nack_pulses", 32'(n_nack_cyc), 32'd1);
    check_val("nack_ncmd", 32'(n_log), 32'd2);
    check_val("nack_stop_only", 32'({log_op[1], log_stop[1]}), 32'h7);
    check_val("nack_no_sample", 32'(n_samp), 32'd3);

    data_val = 8'h77;
    run_tick(0, 0);
    check_val("post_nack_chan", 32'(last_chan), 32'd0);
    check_val("post_nack_data", 32'(last_data), 32'h77);

    // Second tick while busy.
    data_val = 8'h42;
    run_tick(4, 0);
    check_val("overrun_pulses", 32'(n_ovr_cyc), 32'd1);
    check_val("overrun_nsamp", 32'(n_samp), 32'd5);
    check_val("overrun_chan", 32'(last_chan), 32'd2);

    // Enable dropped mid-sequence still completes.
    data_val = 8'h99;
    run_tick(0, 3);
    check_val("en_drop_nsamp", 32'(n_samp), 32'd6);
    check_val("en_drop_chan", 32'(last_chan), 32'd0);

    run_tick(0, 0);
    check_val("disabled_ncmd", 32'(n_log), 32'd0);
    check_val("disabled_nsamp", 32'(n_samp), 32'd6);
    enable = 1'b1;

    chan_mask = 4'b0000;
    run_tick(0, 0);
    check_val("mask0_ncmd", 32'(n_log), 32'd0);
    check_val("mask0_overrun", 32'(n_ovr_cyc), 32'd1);
    chan_mask = 4'b0101;

    // Stall: cmd_ready low for 10 cycles, W_ADDR must hold.
    n_log     = 0;
    cmd_ready = 1'b0;
    data_val  = 8'h3E;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(cmd_valid === 1'b1 && cmd_op === 2'd0 && cmd_start === 1'b1 &&
            cmd_stop === 1'b0 && cmd_data === 8'h90)) bad++;
    end
    check_val("stall_stable", 32'(bad), 32'd0);
    check_val("stall_no_accept", 32'(n_log), 32'd0);
    cmd_ready = 1'b1;
    wait_idle("stall_timeout");
    check_val("stall_chan", 32'(last_chan), 32'd2);
    check_val("stall_data", 32'(last_data), 32'h3E);

    // Reset while in R_DATA of a ch0 scan.
    n_log = 0;
    @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      if (cmd_valid && cmd_op == 2'd2) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check_val("reach_rdata", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check_val("midrst_cmd_valid", 32'(cmd_valid), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_sample_data", 32'(sample_data), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check_val("midrst_no_sample", 32'(n_samp), 32'd7);

    data_val = 8'hC3;
    run_tick(0, 0);
    check_val("after_rst_chan", 32'(last_chan), 32'd0);
    check_val("after_rst_data", 32'(last_data), 32'hC3);
    check_val("after_rst_nsamp", 32'(n_samp), 32'd8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pcf8591_scan_sequencer.md
PCF8591_SCAN_SEQUENCER -- requirements
Module: pcf8591_scan_sequencer

Interface
REQ-001 SHALL have parameter I2C_ADDR, default 7'h48, the PCF8591 7-bit slave address.
REQ-002 SHALL have parameter CHAN_W, default 2, the channel index width (4 channels).
REQ-003 SHALL have port clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port enable  input  1  scan enable, level.
REQ-006 SHALL have port sample_tick  input  1  one-cycle pulse requesting one conversion.
REQ-007 SHALL have port chan_mask  input  4  enabled ADC channels.
REQ-008 SHALL have ports cmd_valid output 1, cmd_ready input 1, cmd_op output 2, cmd_start output 1, cmd_stop output 1, and cmd_data output 8, forming the byte-level I2C master command channel.
REQ-009 SHALL have ports rsp_valid input 1, rsp_data input 8, and rsp_nack input 1, forming the per-command completion from the master.
REQ-010 SHALL have ports sample_valid output 1, sample_data output 8, sample_chan output 2, busy output 1, nack_err output 1 (pulse), and overrun output 1 (pulse).

Function
REQ-011 SHALL encode cmd_op as: 0 WRITE, 1 READ_ACK, 2 READ_NACK, 3 STOP_ONLY.
REQ-012 SHALL hold each command stable from cmd_valid high until the cmd_valid&&cmd_ready cycle; it SHALL issue at most one command outstanding and SHALL wait for rsp_valid before issuing the next command.
REQ-013 SHALL use the states IDLE, W_ADDR, W_CTRL, [W_DAC], R_ADDR, R_DUMMY, R_DATA, EMIT, and RECOVER; each command state SHALL cover both its issue phase and its response wait.
REQ-014 SHALL leave IDLE when sample_tick && enable && chan_mask!=0, choosing the next enabled channel round-robin after the last sampled channel.
REQ-015 SHALL use this transaction sequence: W_ADDR {start, WRITE, I2C_ADDR<<1|0}; W_CTRL {WRITE, control byte = {1'b0, aout_en, 4'b0, ch}, stop}; R_ADDR {start, WRITE, I2C_ADDR<<1|1}; R_DUMMY {READ_ACK}; R_DATA {READ_NACK, stop}.
REQ-016 SHALL discard the R_DUMMY byte, because it is the previous conversion.
REQ-017 SHALL make EMIT pulse sample_valid for exactly 1 cycle with sample_data = R_DATA rsp_data and sample_chan = ch, then return to IDLE.
REQ-018 SHALL make the latency from the accepting tick to sample_valid equal to the command/response time plus 1 cycle for EMIT.
REQ-019 SHALL, on rsp_nack on any WRITE, pulse nack_err for 1 cycle, go to RECOVER (STOP_ONLY), then go to IDLE with no sample; it SHALL still advance the round-robin pointer.
REQ-020 SHALL, when sample_tick arrives while not in IDLE, drop the tick and pulse overrun for 1 cycle.
REQ-021 SHALL, when enable deasserts mid-sequence, complete the current sequence including EMIT, then idle.
REQ-022 SHALL sample chan_mask only at IDLE exit.
REQ-023 SHALL ignore ticks and issue no commands when chan_mask==0.
REQ-024 SHALL drive busy = (state != IDLE).

Reset
REQ-025 SHALL, on reset, force the IDLE state and drive all outputs to 0 (cmd_valid 0 the same cycle after the edge); it SHALL set the round-robin pointer to 3 so that the first scan starts at the lowest enabled channel.
REQ-026 SHALL abandon any operation in progress on reset mid-operation with no stop issued; bus recovery belongs to the master.

Configuration
REQ-027 SHALL, with PCF8591_DAC_EN defined, add input dac_value[7:0], set control-byte bit6 (aout_en) = 1, and insert W_DAC {WRITE, dac_value, stop} after W_CTRL; in that build W_CTRL SHALL carry no stop.
REQ-028 SHALL, with PCF8591_DAC_EN undefined, have no dac_value port, set aout_en = 0, and make the write phase two bytes.

Structure
REQ-029 SHALL place the cmd_op encodings, state enum, and control-byte bit positions in package pcf8591_seq_pkg.
REQ-030 SHALL implement round-robin channel selection in sub-module rr_chan_picker (inputs mask and last channel, output next channel).

Verification
REQ-031 SHALL verify: mask=4'b0101, 3 ticks with an ideal master -> samples on ch0, ch2, ch0; the control bytes SHALL be 0x00, 0x02, 0x00.
REQ-032 SHALL verify: R_DUMMY=0x11 and R_DATA=0xA5 -> sample_data=0xA5, with 0x11 never output.
REQ-033 SHALL verify: rsp_nack on W_ADDR -> nack_err one pulse, a STOP_ONLY command, no sample_valid, and the next tick proceeding on the next channel.
REQ-034 SHALL verify: a second tick while busy -> overrun one pulse and exactly one sample.
REQ-035 SHALL verify: cmd_ready held low for 10 cycles -> cmd_* stable throughout; reset asserted in R_DATA -> cmd_valid 0 and a later scan starting at ch0.
REQ-036 SHALL verify: with PCF8591_DAC_EN and dac_value=0x80 -> the write bytes are 0x90, 0x4n, 0x80 with stop on the third.
